alu_ctrl_seq: RTL and testbench

Registered, multi-cycle-aware ALU control unit for the EX stage of the pipelined RISC-V core. Decodes {funct7, funct3} and ALUOp into the 4-bit ALU control code. Sequences multi-cycle M-extension operations (mul, optionally div/rem) with a programmable latency counter, and raises a stall to the hazard unit while they are in flight. Sits between the ID/EX pipeline register and the ALU / iterative multiplier.

---
 rtl/alu_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: decodes {funct7,funct3}/ALUOp into a registered 4-bit code and
// sequences multi-cycle mul (and div/rem when ALU_CTRL_DIV_EN is defined) with a stall.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [9:0] funct_i,
  input  logic [1:0] ALUOp_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic [3:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       illegal_o
);

`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Counter preloads; only meaningful when the matching latency exceeds one.
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 2);
  localparam logic             MUL_MULTI = (MUL_LAT > 1);
  localparam logic             DIV_MULTI = (DIV_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       ctrl_reg, ctrl_next;
  logic             valid_reg, valid_next;
  logic             illegal_reg, illegal_next;

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_load;
  logic             accept;

  always_comb begin
    dec_code    = 4'b1111;
    dec_illegal = 1'b1;
    dec_multi   = 1'b0;
    dec_load    = '0;
    case (ALUOp_i)
      2'b10: begin
        case (funct_i)
          10'b0000000111: begin dec_code = 4'b0000; dec_illegal = 1'b0; end
          10'b0000000100: begin dec_code = 4'b0001; dec_illegal = 1'b0; end
          10'b0000000001: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
          10'b0000000000: begin dec_code = 4'b0011; dec_illegal = 1'b0; end
          10'b0100000000: begin dec_code = 4'b0100; dec_illegal = 1'b0; end
          10'b0000001000: begin
            dec_code    = 4'b0101;
            dec_illegal = 1'b0;
            dec_multi   = MUL_MULTI;
            dec_load    = MUL_LOAD;
          end
          10'b0000001100: begin
            if (DIV_EN) begin
              dec_code    = 4'b1010;
              dec_illegal = 1'b0;
              dec_multi   = DIV_MULTI;
              dec_load    = DIV_LOAD;
            end
          end
          10'b0000001110: begin
            if (DIV_EN) begin
              dec_code    = 4'b1011;
              dec_illegal = 1'b0;
              dec_multi   = DIV_MULTI;
              dec_load    = DIV_LOAD;
            end
          end
          default: ;
        endcase
      end
      2'b00: begin
        case (funct_i[2:0])
          3'b000: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
          3'b101: begin dec_code = 4'b0111; dec_illegal = 1'b0; end
          3'b010: begin dec_code = 4'b1000; dec_illegal = 1'b0; end
          default: ;
        endcase
      end
      2'b01: begin dec_code = 4'b1001; dec_illegal = 1'b0; end
      default: ;
    endcase
  end

  // Flush beats a simultaneous valid, so nothing is taken on a flushing edge.
  assign accept = valid_i & (state_reg == IDLE) & ~flush_i;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ctrl_next    = ctrl_reg;
    valid_next   = 1'b0;
    illegal_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          ctrl_next = dec_code;
          if (dec_multi) begin
            state_next = BUSY;
            cnt_next   = dec_load;
          end else begin
            valid_next   = 1'b1;
            illegal_next = dec_illegal;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
          valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ctrl_reg    <= 4'b0000;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ctrl_reg    <= ctrl_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
    end
  end

  assign ready_o   = (state_reg != BUSY);
  assign busy_o    = (state_reg == BUSY);
  assign ALUCtrl_o = ctrl_reg;
  assign valid_o   = valid_reg;
  assign illegal_o = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: directed ops push expected {illegal,code};
// a negedge monitor pops and compares on every valid_o pulse.
module tb_alu_ctrl_seq;

  logic       clk_i;
  logic       rst_i;
  logic       valid_i;
  logic [9:0] funct_i;
  logic [1:0] ALUOp_i;
  logic       flush_i;
  logic       ready_o;
  logic [3:0] ALUCtrl_o;
  logic       valid_o;
  logic       busy_o;
  logic       illegal_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  localparam logic [9:0] F_AND = 10'b0000000111;
  localparam logic [9:0] F_XOR = 10'b0000000100;
  localparam logic [9:0] F_SLL = 10'b0000000001;
  localparam logic [9:0] F_ADD = 10'b0000000000;
  localparam logic [9:0] F_SUB = 10'b0100000000;
  localparam logic [9:0] F_MUL = 10'b0000001000;
  localparam logic [9:0] F_DIV = 10'b0000001100;

  alu_ctrl_seq #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(5)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .funct_i   (funct_i),
    .ALUOp_i   (ALUOp_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .ALUCtrl_o (ALUCtrl_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .illegal_o (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // Monitor: every valid_o cycle must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got ctrl=%b ill=%b expected no valid_o (t=%0t)",
                   ALUCtrl_o, illegal_o, $time);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("sb_result", {27'd0, illegal_o, ALUCtrl_o}, {27'd0, e});
        end
      end else if (illegal_o) begin
        n_cmp++;
        n_err++;
        $display("FAIL illegal_no_valid: got illegal_o=1 expected 0 (t=%0t)", $time);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [9:0] f,
                       input logic [3:0] ec, input logic ei, input bit push);
    valid_i = 1'b1;
    ALUOp_i = op;
    funct_i = f;
    if (push) exp_q.push_back({ei, ec});
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // Counts negedges with busy_o high; returns at the first idle negedge.
  task automatic count_busy(input string name, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int nb;
    valid_i = 1'b0;
    funct_i = '0;
    ALUOp_i = 2'b00;
    flush_i = 1'b0;
    rst_i   = 1'b0;

    #12;
    chk("rst_ctrl",    {28'd0, ALUCtrl_o}, 32'h0);
    chk("rst_valid",   {31'd0, valid_o},   32'd0);
    chk("rst_busy",    {31'd0, busy_o},    32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst_ready",   {31'd0, ready_o},   32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Back-to-back single-cycle ops
    issue(2'b10, F_ADD, 4'b0011, 1'b0, 1);
    issue(2'b10, F_SUB, 4'b0100, 1'b0, 1);
    issue(2'b00, 10'b1111111000, 4'b0110, 1'b0, 1);
    chk("b2b_busy", {31'd0, busy_o}, 32'd0);
    issue(2'b00, 10'b0000000010, 4'b1000, 1'b0, 1);
    issue(2'b01, 10'b1010101010, 4'b1001, 1'b0, 1);
    issue(2'b10, F_AND, 4'b0000, 1'b0, 1);
    issue(2'b00, 10'b0100000101, 4'b0111, 1'b0, 1);
    issue(2'b10, F_SLL, 4'b0010, 1'b0, 1);

    // Illegal encodings
    issue(2'b11, F_ADD, 4'b1111, 1'b1, 1);
    issue(2'b10, 10'b0000000010, 4'b1111, 1'b1, 1);
    issue(2'b00, 10'b0000000011, 4'b1111, 1'b1, 1);
    @(posedge clk_i);
    #1;

    // mul with a held xor behind it
    issue(2'b10, F_MUL, 4'b0101, 1'b0, 1);
    chk("mul_ready_low", {31'd0, ready_o}, 32'd0);
    chk("mul_ctrl_early", {28'd0, ALUCtrl_o}, 32'h5);
    valid_i = 1'b1;
    ALUOp_i = 2'b10;
    funct_i = F_XOR;
    exp_q.push_back({1'b0, 4'b0001});
    count_busy("mul", nb);
    chk("mul_busy_cycles", nb, 32'd3);
    chk("mul_ready_on_valid", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("xor_after_mul", {28'd0, ALUCtrl_o}, 32'h1);
    @(posedge clk_i);
    #1;

    // Flush during the second busy cycle of mul
    issue(2'b10, F_MUL, 4'b0101, 1'b0, 0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    chk("flush_ctrl_hold", {28'd0, ALUCtrl_o}, 32'h5);
    @(posedge clk_i);
    #1;
    issue(2'b10, F_ADD, 4'b0011, 1'b0, 1);

    // Flush wins over valid in IDLE
    valid_i = 1'b1;
    flush_i = 1'b1;
    ALUOp_i = 2'b10;
    funct_i = F_SUB;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("idle_flush_hold", {28'd0, ALUCtrl_o}, 32'h3);
    @(posedge clk_i);
    #1;

    // div
`ifdef ALU_CTRL_DIV_EN
    issue(2'b10, F_DIV, 4'b1010, 1'b0, 1);
    count_busy("div", nb);
    chk("div_busy_cycles", nb, 32'd15);
    @(posedge clk_i);
    #1;
`else
    issue(2'b10, F_DIV, 4'b1111, 1'b1, 1);
    chk("div_busy", {31'd0, busy_o}, 32'd0);
    issue(2'b10, 10'b0000001110, 4'b1111, 1'b1, 1);
`endif

    // Reset in the middle of a mul
    issue(2'b10, F_MUL, 4'b0101, 1'b0, 0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_ctrl",  {28'd0, ALUCtrl_o}, 32'h0);
    chk("midrst_busy",  {31'd0, busy_o},    32'd0);
    chk("midrst_ready", {31'd0, ready_o},   32'd1);
    chk("midrst_valid", {31'd0, valid_o},   32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    issue(2'b10, F_SUB, 4'b0100, 1'b0, 1);

    repeat (4) @(posedge clk_i);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
